// File: rtl/hci_bank_resp_tracker.sv
// hci_bank_resp_tracker: forwards arbiter requests to one TCDM bank and returns in-order, credit-gated responses.
module hci_bank_resp_tracker #(
    parameter int DW         = 32,
    parameter int IW         = 8,
    parameter int MEM_LAT    = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int WRITE_RESP = 0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_i,
    output logic          gnt_o,
    input  logic          wen_i,
    input  logic [IW-1:0] id_i,
    input  logic          sel_high_i,
    output logic          bank_req_o,
    input  logic [DW-1:0] bank_rdata_i,
    output logic          r_valid_high_o,
    output logic          r_valid_low_o,
    input  logic          r_ready_high_i,
    input  logic          r_ready_low_i,
    output logic [DW-1:0] r_data_o,
    output logic [IW-1:0] r_id_o
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int SW = IW + 3;
    localparam int EW = DW + IW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);
    localparam logic WR = (WRITE_RESP != 0);

    logic [CW-1:0] r_credits, r_count;
    logic [PW-1:0] r_wptr, r_rptr;
    logic [SW-1:0] r_pipe [MEM_LAT];
    logic [EW-1:0] r_mem [FIFO_DEPTH];
    logic          w_accept, w_push, w_pop, w_wdrop, w_empty, w_full;
    logic [SW-1:0] w_last;
    logic [EW-1:0] w_head;
    logic [DW-1:0] w_wdata;

    assign gnt_o      = !rst_i && (r_credits < DEPTH);
    assign w_accept   = req_i && gnt_o;
    assign bank_req_o = w_accept;
    // pipeline stage layout: {valid, is_read, side, id}
    assign w_last  = r_pipe[MEM_LAT-1];
    assign w_push  = w_last[SW-1] && (w_last[SW-2] || WR);
    assign w_wdrop = w_last[SW-1] && !w_last[SW-2] && !WR;
    assign w_wdata = w_last[SW-2] ? bank_rdata_i : '0;
    // fifo entry layout: {data, id, side}
    assign w_empty        = rst_i || (r_count == '0);
    assign w_full         = (r_count == DEPTH);
    assign w_head         = r_mem[r_rptr];
    assign r_valid_high_o = !w_empty && w_head[0];
    assign r_valid_low_o  = !w_empty && !w_head[0];
    assign r_id_o         = w_empty ? '0 : w_head[IW:1];
    assign r_data_o       = w_empty ? '0 : w_head[EW-1:IW+1];
    assign w_pop          = (r_valid_high_o && r_ready_high_i) || (r_valid_low_o && r_ready_low_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_credits <= '0;
            r_count   <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            for (int k = 0; k < MEM_LAT; k++) r_pipe[k] <= '0;
        end else begin
            r_credits <= r_credits + CW'(w_accept) - CW'(w_pop) - CW'(w_wdrop);
            r_count   <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_push) r_wptr <= (r_wptr == LAST) ? '0 : r_wptr + PW'(1);
            if (w_pop) r_rptr <= (r_rptr == LAST) ? '0 : r_rptr + PW'(1);
            r_pipe[0] <= {w_accept, wen_i, sel_high_i, id_i};
            for (int k = 1; k < MEM_LAT; k++) r_pipe[k] <= r_pipe[k-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= {w_wdata, w_last[IW-1:0], w_last[IW]};
    end

    assert property (@(posedge clk_i) disable iff (rst_i) !(w_push && w_full));
endmodule
